// File: rtl/nibble_fifo_pkg.sv
// Shared types and constants for the nibble FIFO buffer stage.
package nibble_fifo_pkg;

  // Word width produced by the upstream 4-bit D-register stage.
  localparam int NIBBLE_W = 4;

  // Default number of storage entries (power of two, at least 2).
  localparam int FIFO_DEPTH_DFLT = 8;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage : nibble_fifo_pkg

// File: rtl/nibble_fifo_mem.sv
// DEPTH x WIDTH register array: one clocked write port, one combinational read port.
module nibble_fifo_mem
  import nibble_fifo_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W,
  parameter int DEPTH = FIFO_DEPTH_DFLT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address when enabled.
  // NOTE: storage has no reset; validity is tracked by the pointers and count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Show-ahead read: the addressed word is visible without a clock.
  assign rdata = mem[raddr];

endmodule : nibble_fifo_mem

// File: rtl/nibble_fifo.sv
// Circular-buffer FIFO decoupling the per-clock nibble stream from a stalling consumer.
module nibble_fifo
  import nibble_fifo_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W,
  parameter int DEPTH = FIFO_DEPTH_DFLT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic             overflow_set;
  logic             underflow_set;
  logic [WIDTH-1:0] mem_rdata;

  // Request qualification: flush swallows both requests and any error they would raise.
  // A push into a full buffer still fits when the head is leaving on the same edge.
  assign push_ok       = !flush && wr_en && (!full || rd_en);
  assign pop_ok        = !flush && rd_en && !empty;
  assign overflow_set  = !flush && wr_en && full && !rd_en;
  assign underflow_set = !flush && rd_en && empty;

  // Next fill level; full/empty are registered from this value.
  // NOTE: assign the default first so every path drives count_nxt and no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointer, count and status-flag state.
  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_CNT);
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_set)      overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (underflow_set)     underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  nibble_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Head word is forced to zero while nothing valid is stored.
  assign rd_data = empty ? '0 : mem_rdata;

endmodule : nibble_fifo

// File: tb/tb_nibble_fifo.sv
// Self-checking bench for nibble_fifo: directed scenarios plus random traffic against a queue model.
module tb_nibble_fifo;
  import nibble_fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH_DFLT;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  nibble_t       wr_data;
  logic          full;
  logic          rd_en;
  nibble_t       rd_data;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents in arrival order plus the two sticky flags.
  nibble_t q[$];
  logic    m_ovf;
  logic    m_unf;

  nibble_fifo #(.WIDTH(NIBBLE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    nibble_t head;
    head = (q.size() != 0) ? q[0] : '0;
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".rd_data"},   32'(rd_data),   32'(head));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Apply the FIFO rules to the model for one clock edge with the given requests.
  task automatic model_edge(input logic wr, input nibble_t wd, input logic rd,
                            input logic fl, input logic clr);
    logic was_full, was_empty, ovf_new, unf_new;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ovf_new = 1'b0;
    unf_new = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      ovf_new = wr && was_full && !rd;
      unf_new = rd && was_empty;
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && (!was_full || rd)) q.push_back(wd);
    end
    if (ovf_new) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (unf_new) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
  endtask

  // Drive one cycle of requests, clock it, then check #1 after the edge.
  task automatic step(input string tag, input logic wr, input nibble_t wd, input logic rd,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    flush   = fl;
    err_clr = clr;
    @(posedge clk);
    model_edge(wr, wd, rd, fl, clr);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_data = '0; rd_en = 0; flush = 0; err_clr = 0;
  endtask

  initial begin
    nibble_t last_pop;
    idle_inputs();
    q.delete();
    m_ovf = 0;
    m_unf = 0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Push 1,2,3 on consecutive cycles; head appears one cycle after the first push.
    step("push1", 1, 4'h1, 0);
    step("push2", 1, 4'h2, 0);
    step("push3", 1, 4'h3, 0);
    for (int i = 0; i < 3; i++) step("drain123", 0, '0, 1);

    // Fill to DEPTH, overflow attempt, then drain in order.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, nibble_t'(i), 0);
    step("ovf_push", 1, 4'h9, 0);
    for (int i = 0; i < DEPTH; i++) step("drain_fill", 0, '0, 1);
    step("clr_ovf", 0, '0, 0, 0, 1);

    // Full with simultaneous push and pop; 0xA must come out last.
    for (int i = 0; i < DEPTH; i++) step("refill", 1, nibble_t'(i), 0);
    step("full_push_pop", 1, 4'hA, 1);
    for (int i = 0; i < DEPTH; i++) begin
      last_pop = rd_data;
      step("drain_a", 0, '0, 1);
    end
    check("last_word_a", 32'(last_pop), 32'h0000_000A);

    // Empty with push and pop together: push wins, underflow raised, then cleared.
    step("empty_push_pop", 1, 4'h5, 1);
    step("clr_unf", 0, '0, 0, 0, 1);
    step("drain5", 0, '0, 1);

    // Alternating push/pop pairs across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      step("wrap_push", 1, nibble_t'(i), 0);
      check("wrap_cnt_le1", 32'(count <= 1), 32'h1);
      step("wrap_pop", 0, '0, 1);
    end

    // Flush with count=5 and a concurrent push.
    for (int i = 0; i < 5; i++) step("pre_flush", 1, nibble_t'(i + 3), 0);
    step("flush", 1, 4'hF, 0, 1);

    // Asynchronous reset mid-stream, checked before the next clock edge.
    for (int i = 0; i < 4; i++) step("pre_rst", 1, nibble_t'(i + 7), 0);
    step("pre_rst_ovf", 0, '0, 1);
    step("pre_rst_unf", 0, '0, 1);
    step("pre_rst_ovf2", 0, '0, 0);
    rst_n = 1'b0;
    idle_inputs();
    #2;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic    wr, rd, fl, clr;
      nibble_t wd;
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 8);
      wd  = nibble_t'($urandom);
      step("rand", wr, wd, rd, fl, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_fifo
